// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU share arbiter and its clients.
//   alu_op_t    : 2-bit ALU opcode. All four encodings are valid operations.
//   FLAG_*      : bit positions inside the 4-bit flag word {V,C,N,Z}.
//   arb_state_t : arbiter FSM state.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: bundles the requester-side and ALU-side buses of the arbiter.
//   req_valid/req_ready/req_op/req_a/req_b : per-requester request channel (ready is one-hot)
//   rsp_valid/rsp_ready/rsp_result/rsp_flags : per-requester response, result/flags are shared
//   alu_control/alu_src_a/alu_src_b         : registered operands toward the ALU
//   alu_result/alu_flags                    : combinational answer from the ALU
// Modports: slave = arbiter side, master = clients + ALU side.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int RES_W   = 18
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][1:0]        req_op;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_b;

    logic [1:0]                     alu_control;
    logic [DATA_W-1:0]              alu_src_a;
    logic [DATA_W-1:0]              alu_src_b;
    logic [RES_W-1:0]               alu_result;
    logic [3:0]                     alu_flags;

    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_ready;
    logic [RES_W-1:0]               rsp_result;
    logic [3:0]                     rsp_flags;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_flags,
        output req_ready, alu_control, alu_src_a, alu_src_b, rsp_valid, rsp_result, rsp_flags
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_flags,
        input  req_ready, alu_control, alu_src_a, alu_src_b, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : binary index of the grant
//   any     : at least one request present
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);
    // One extra bit so ptr + offset never overflows before the modulo fold.
    logic [IDX_W:0] cand;

    // Scan offsets from farthest to nearest so the nearest valid index
    // at or after ptr is the last one written.
    always_comb begin
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign any = |req;

    always_comb begin
        gnt = '0;
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one ALU between NUM_REQ requesters.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of alu_share_arbiter_if (requests, responses, ALU operands/results)
//   busy : high whenever the FSM is not IDLE
// One transaction at a time: IDLE (grant + latch operands) -> EXEC (ALU evaluates,
// result captured) -> RESP (hold response until the granted requester accepts).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int RES_W   = 18
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus,
    output logic               busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    alu_op_t             alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   src_a_q, src_a_d;
    logic [DATA_W-1:0]   src_b_q, src_b_d;
    logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]  req_ready;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        alu_op_d     = alu_op_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = '0;
        unique case (state_q)
            IDLE: begin
                // rst gate keeps req_ready from pulsing while the flops are being cleared.
                if (arb_any && !rst) begin
                    req_ready = arb_gnt;
                    gnt_d     = arb_idx;
                    alu_op_d  = alu_op_t'(bus.req_op[arb_idx]);
                    src_a_d   = bus.req_a[arb_idx];
                    src_b_d   = bus.req_b[arb_idx];
                    rr_ptr_d  = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d        = bus.alu_result;
                rsp_flags_d         = bus.alu_flags;
                rsp_valid_d         = '0;
                rsp_valid_d[gnt_q]  = 1'b1;
                state_d             = RESP;
            end
            RESP: begin
                // Only the granted requester's ready completes the handshake.
                if (bus.rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            alu_op_q     <= ALU_ADD;
            src_a_q      <= '0;
            src_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            alu_op_q     <= alu_op_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.alu_control = alu_op_q;
    assign bus.alu_src_a   = src_a_q;
    assign bus.alu_src_b   = src_b_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_flags   = rsp_flags_q;
    assign busy            = (state_q != IDLE);
endmodule
